// File: rtl/text_pkg.sv
// Shared constants and state encoding for the character-cell text buffer.
package text_pkg;
    localparam int TXT_COLS  = 32;
    localparam int TXT_ROWS  = 4;
    localparam int TXT_CELLS = 128;

    localparam logic [6:0] SPACE = 7'h20;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;

    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK} state_t;
endpackage

// File: rtl/text_ram.sv
// 128x7 cell store: one write port, a synchronous display read port and an
// asynchronous read port used as the scroll source.
import text_pkg::*;

module text_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [6:0] wdata,
    input  logic [6:0] raddr,
    output logic [6:0] rdata,
    input  logic [6:0] aaddr,
    output logic [6:0] adata
);
    logic [6:0] mem [0:TXT_CELLS-1];

    // Non-blocking update gives read-before-write on a same-cell collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

    assign adata = mem[aaddr];
endmodule

// File: rtl/text_buffer.sv
// Text cell store with cursor engine: accepts a byte stream, handles control
// characters and scrolling, and answers pixel lookups with the covering cell code.
import text_pkg::*;

module text_buffer #(
    parameter int X0 = 192,
    parameter int Y0 = 208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [6:0] ascii_code,
    output logic [4:0] cursor_col,
    output logic [1:0] cursor_row
);
    localparam logic [9:0] X0_L = 10'(X0);
    localparam logic [9:0] Y0_L = 10'(Y0);

    state_t     state;
    logic [6:0] idx;
    logic       we;
    logic [6:0] waddr;
    logic [6:0] wdata;
    logic [6:0] adata;
    logic [6:0] raddr;
    logic [6:0] rdata;
    logic       in_win;
    logic       win_q;
    logic       accept;
    logic       printable;

    assign accept    = in_valid && in_ready && !in_data[7];
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    // Display lookup; the window flag is delayed to line up with the RAM read.
    assign in_win = (x >= X0_L) && (x < X0_L + 10'd256) &&
                    (y >= Y0_L) && (y < Y0_L + 10'd64);
    assign raddr  = {2'((y - Y0_L) >> 4), 5'((x - X0_L) >> 3)};

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= 1'b0;
        end else begin
            win_q <= in_win;
        end
    end

    assign ascii_code = win_q ? rdata : SPACE;

    always_comb begin
        we    = 1'b0;
        waddr = idx;
        wdata = SPACE;
        case (state)
            CLEAR, SCROLL_BLANK: we = 1'b1;
            SCROLL_COPY: begin
                we    = 1'b1;
                wdata = adata;
            end
            IDLE: begin
                if (accept && printable) begin
                    we    = 1'b1;
                    waddr = {cursor_row, cursor_col};
                    wdata = in_data[6:0];
                end else if (accept && in_data == BS) begin
                    if (cursor_col != 5'd0) begin
                        we    = 1'b1;
                        waddr = {cursor_row, cursor_col - 5'd1};
                    end else if (cursor_row != 2'd0) begin
                        we    = 1'b1;
                        waddr = {cursor_row - 2'd1, 5'd31};
                    end
                end
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            idx        <= 7'd0;
            cursor_col <= 5'd0;
            cursor_row <= 2'd0;
            in_ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cursor_col <= 5'd0;
                    cursor_row <= 2'd0;
                    idx        <= idx + 7'd1;
                    if (idx == 7'd127) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                SCROLL_COPY: begin
                    idx <= idx + 7'd1;
                    if (idx == 7'd95) begin
                        state <= SCROLL_BLANK;
                    end
                end
                SCROLL_BLANK: begin
                    idx <= idx + 7'd1;
                    if (idx == 7'd127) begin
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        cursor_row <= 2'd3;
                        cursor_col <= 5'd0;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            cursor_col <= cursor_col + 5'd1;
                            if (cursor_col == 5'd31) begin
                                if (cursor_row == 2'd3) begin
                                    state    <= SCROLL_COPY;
                                    idx      <= 7'd0;
                                    in_ready <= 1'b0;
                                end else begin
                                    cursor_row <= cursor_row + 2'd1;
                                end
                            end
                        end else if (in_data == LF || in_data == CR) begin
                            cursor_col <= 5'd0;
                            if (cursor_row == 2'd3) begin
                                state    <= SCROLL_COPY;
                                idx      <= 7'd0;
                                in_ready <= 1'b0;
                            end else begin
                                cursor_row <= cursor_row + 2'd1;
                            end
                        end else if (in_data == BS) begin
                            if (cursor_col != 5'd0) begin
                                cursor_col <= cursor_col - 5'd1;
                            end else if (cursor_row != 2'd0) begin
                                cursor_row <= cursor_row - 2'd1;
                                cursor_col <= 5'd31;
                            end
                        end else if (in_data == FF) begin
                            state      <= CLEAR;
                            idx        <= 7'd0;
                            in_ready   <= 1'b0;
                            cursor_col <= 5'd0;
                            cursor_row <= 2'd0;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    text_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .aaddr (idx + 7'(TXT_COLS)),
        .adata (adata)
    );
endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell store and cursor engine that drives `ascii_code` into the VGA text renderer.
- The renderer's text window is 256x64 px at (192,208), 8x16 glyphs, so the grid is 32 columns x 4 rows = 128 cells.
- Accepts a byte stream (UART/keyboard) over a valid/ready handshake, handles control characters, and scrolls.
- Answers pixel-coordinate lookups with the ASCII code of the covering cell.

Parameters:
- X0, 192, left pixel edge of text window.
- Y0, 208, top pixel edge of text window.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  byte accepted when in_valid & in_ready
- x  in  10  current pixel column from VGA sync
- y  in  10  current pixel row from VGA sync
- ascii_code  out  7  code of cell covering (x,y), registered
- cursor_col  out  5  cursor column 0..31
- cursor_row  out  2  cursor row 0..3

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: `cursor_col`=0, `cursor_row`=0, `ascii_code`=7'h20, `in_ready`=0, state=CLEAR with clear index 0.
- Reset asserted in any state, including mid-SCROLL or mid-CLEAR, aborts that state and restarts CLEAR.
- Display read path:
  - cell index = {row, col}, with col = (x-X0)>>3 [4:0] and row = (y-Y0)>>4 [1:0].
  - `ascii_code` is registered with 1-cycle latency from x,y.
  - Outside the window (x<X0, x>=X0+256, y<Y0, y>=Y0+64) the output is 7'h20.
  - The read port is independent of the write engine and is never stalled.
- States:
  - CLEAR: writes 7'h20 to cells 0..127, one per cycle (128 cycles). Cursor is (0,0). Then goes to IDLE.
  - IDLE: `in_ready`=1. Acts on one accepted byte per cycle.
  - SCROLL_COPY: 96 cycles. Cycle k writes cell k with the contents of cell k+32.
  - SCROLL_BLANK: 32 cycles. Writes 7'h20 to cells 96..127. Then cursor = (row 3, col 0) and state goes to IDLE.
  - `in_ready`=0 in every state except IDLE. Scroll total is 128 cycles.
- Byte handling in IDLE (all accepted bytes are consumed; there is no back-pressure beyond the state):
  - in_data[7]=1: ignored.
  - 0x20..0x7E: write in_data[6:0] at the cursor, then col+1. At col 31 the column wraps to 0 and row+1. If row was 3, enter SCROLL_COPY.
  - 0x0A or 0x0D: col=0. If row<3, row+1. Otherwise enter SCROLL_COPY.
  - 0x08 (backspace): at col>0, col-1 and write 7'h20 at the new cell. At col=0 with row>0, row-1, col=31 and write 7'h20 there. At (0,0), no-op.
  - 0x0C (form feed): enter CLEAR.
  - Any other code: ignored.
- Simultaneous display read and engine write to the same cell: the display returns the old value (read-before-write).
- Cursor outputs are registered and update in the cycle after acceptance.

Decomposition:
- Shared package (text_pkg) holds:
  - constants TXT_COLS=32, TXT_ROWS=4, TXT_CELLS=128
  - ASCII constants SPACE=7'h20, BS=8'h08, LF=8'h0A, FF=8'h0C, CR=8'h0D
  - state enum {CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK}
- Sub-module text_ram: 128x7 storage with
  - one write port
  - one synchronous read port (display)
  - one asynchronous read port (scroll source)

Test Plan:
- Reset pulse, then in_valid held high -> `in_ready` low for exactly 128 cycles. Afterwards x=192..447, y=208..271 all return 0x20 one cycle later.
- Send 'H','I' -> (x=192,y=208) gives 0x48. (x=200,y=208) gives 0x49. Cursor is (row 0, col 2). (x=100,y=100) gives 0x20.
- Send 32 'A' from (0,0) -> cursor (row 1, col 0). Cell (0,31) = 0x41. 'B' lands at x=192, y=224.
- Fill rows 0..3 with row-distinct letters 'a','b','c','d', then send 'e' -> `in_ready` low for 128 cycles. Row 0 now reads 'b', row 2 reads 'd', row 3 reads 0x20. Cursor (3,0). Then 'e' is written there on the next accept.
- At (1,0) send 0x08 -> cursor (0,31) and cell (0,31)=0x20. At (0,0) send 0x08 -> no change. Send 0x0C -> 128-cycle clear, cursor (0,0).
- Assert reset 40 cycles into SCROLL_COPY -> CLEAR restarts. After 128 cycles all cells are 0x20 and `in_ready`=1.
